// File: rtl/slave_port.sv
// slave_port: serial-bus responder; decodes the device select, deserialises address/write data,
// performs one local memory access and serialises read data back to the initiator.
module slave_port #(
    parameter logic [5:0] DEV_ID   = 6'b000001,
    parameter bit         SPLIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       mode,
    input  logic       wr_bus,
    output logic       rd_bus,
    output logic       ack,
    input  logic       master_valid,
    output logic       slave_ready,
    input  logic       master_ready,
    output logic       slave_valid,
    output logic       split,
    output logic [9:0] s_addr,
    output logic [7:0] s_wr_data,
    output logic       s_wr_en,
    output logic       s_rd_en,
    input  logic [7:0] s_rd_data,
    input  logic       s_rd_valid
);
    typedef enum logic [2:0] {IDLE, ADDR_SEL, ADDR_LO, WDATA, WRITE, RD_WAIT, RDATA, IGNORE} state_t;

    state_t     state, state_n;
    logic       t_mode, rd_first, wr_xfer, rd_xfer, sel_hit, rd_done;
    logic [3:0] bit_cnt;
    logic [4:0] sel_sr;
    logic [7:0] wdata_sr, rd_sr;

    assign slave_ready = state inside {ADDR_SEL, ADDR_LO, WDATA};
    assign slave_valid = state == RDATA;
    assign wr_xfer     = master_valid & slave_ready;
    assign rd_xfer     = slave_valid & master_ready;
    assign sel_hit     = {sel_sr, wr_bus} == DEV_ID;
    assign ack         = state == ADDR_SEL && bit_cnt == 4'd5 && master_valid && sel_hit;
    assign split       = SPLIT_EN && state == RD_WAIT;
    assign rd_bus      = rd_sr[7];
    assign s_wr_en     = state == WRITE;
    assign s_wr_data   = wdata_sr;
    assign s_rd_en     = rd_first;
    // data arriving alongside the read strobe is too early to be a response
    assign rd_done     = state == RD_WAIT && s_rd_valid && !rd_first;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = master_valid ? ADDR_SEL : IDLE;
            ADDR_SEL: state_n = !master_valid ? IDLE : bit_cnt == 4'd5 ? (sel_hit ? ADDR_LO : IGNORE) : ADDR_SEL;
            ADDR_LO:  state_n = !master_valid ? IDLE : bit_cnt == 4'd9 ? (t_mode ? WDATA : RD_WAIT) : ADDR_LO;
            WDATA:    state_n = !master_valid ? IDLE : bit_cnt == 4'd7 ? WRITE : WDATA;
            RD_WAIT:  state_n = rd_done ? RDATA : RD_WAIT;
            RDATA:    state_n = rd_xfer && bit_cnt == 4'd7 ? IDLE : RDATA;
            IGNORE:   state_n = master_valid ? IGNORE : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t_mode   <= 1'b0;
            rd_first <= 1'b0;
            bit_cnt  <= '0;
            sel_sr   <= '0;
            s_addr   <= '0;
            wdata_sr <= '0;
            rd_sr    <= '0;
        end else begin
            t_mode   <= state == IDLE && master_valid ? mode : t_mode;
            rd_first <= state_n == RD_WAIT && state != RD_WAIT;
            bit_cnt  <= state_n != state ? 4'd0 : bit_cnt + 4'(wr_xfer | rd_xfer);
            if (wr_xfer && state == ADDR_SEL) sel_sr <= {sel_sr[3:0], wr_bus};
            if (wr_xfer && state == ADDR_LO) s_addr <= {s_addr[8:0], wr_bus};
            if (wr_xfer && state == WDATA) wdata_sr <= {wdata_sr[6:0], wr_bus};
            if (rd_done) rd_sr <= s_rd_data;
            else if (rd_xfer) rd_sr <= {rd_sr[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_slave_port.sv
// tb_slave_port: scoreboard bench; stimulus queues expected strobes/bits, a negedge monitor checks them.
module tb_slave_port;
    logic       clk = 0, rstn = 1, mode = 0, wr_bus = 0, master_valid = 0, master_ready = 1, s_rd_valid = 0;
    logic [7:0] s_rd_data = 0;
    logic       rd_bus, ack, slave_ready, slave_valid, split, s_wr_en, s_rd_en;
    logic [9:0] s_addr;
    logic [7:0] s_wr_data;

    slave_port dut (
        .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus), .ack(ack),
        .master_valid(master_valid), .slave_ready(slave_ready), .master_ready(master_ready),
        .slave_valid(slave_valid), .split(split), .s_addr(s_addr), .s_wr_data(s_wr_data),
        .s_wr_en(s_wr_en), .s_rd_en(s_rd_en), .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid)
    );

    always #5 clk = ~clk;

    int          checks = 0, passes = 0;
    logic [17:0] wr_q[$];
    logic [9:0]  rd_q[$];
    logic        bit_q[$];
    int          ack_q[$], split_q[$];
    int          rd_lat = 3, wr_bits = 0, rd_bits = 0, sp_cnt = 0;
    logic [7:0]  mem_data = 0;
    logic        sv_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ack) begin
            if (ack_q.size() == 0) check("unexpected ack", ack, 0);
            else check("ack on 6th bit", wr_bits, ack_q.pop_front());
        end
        wr_bits = !master_valid ? 0 : wr_bits + int'(slave_ready);
        if (s_wr_en) begin
            if (wr_q.size() == 0) check("unexpected s_wr_en", s_wr_en, 0);
            else check("write addr/data", {s_addr, s_wr_data}, wr_q.pop_front());
        end
        if (s_rd_en) begin
            if (rd_q.size() == 0) check("unexpected s_rd_en", s_rd_en, 0);
            else check("read addr", s_addr, rd_q.pop_front());
            check("split with s_rd_en", split, 1);
            sp_cnt = 0;
        end else if (split) sp_cnt++;
        if (slave_valid && !sv_prev) begin
            if (split_q.size() == 0) check("unexpected slave_valid", slave_valid, 0);
            else check("split wait cycles", sp_cnt, split_q.pop_front());
        end
        sv_prev = slave_valid;
        if (slave_valid && master_ready) begin
            rd_bits++;
            if (bit_q.size() == 0) check("unexpected rd bit", slave_valid, 0);
            else check("rd_bus bit", rd_bus, bit_q.pop_front());
        end
    end

    // memory model: answers each read strobe rd_lat cycles later
    initial forever begin
        @(negedge clk);
        if (s_rd_en) begin
            repeat (rd_lat) @(posedge clk);
            #1 s_rd_valid = 1; s_rd_data = mem_data;
            @(posedge clk);
            #1 s_rd_valid = 0; s_rd_data = 0;
        end
    end

    task automatic send_bits(input logic [15:0] v, input int n, output int first_wait);
        bit done;
        master_valid = 1;
        first_wait = -1;
        for (int i = 0; i < n; i++) begin
            done = 0;
            wr_bus = v[n-1-i];
            for (int t = 0; t < 16 && !done; t++) begin
                @(negedge clk);
                if (slave_ready) begin
                    if (i == 0) first_wait = t;
                    @(posedge clk);
                    #1;
                    done = 1;
                end
            end
            if (!done) begin
                check("wr bit accept timeout", slave_ready, 1);
                return;
            end
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        int w;
        ack_q.push_back(5);
        wr_q.push_back({addr[9:0], data});
        mode = 1;
        send_bits(addr, 16, w);
        check("write accept latency", w, 1);
        send_bits({8'h00, data}, 8, w);
        master_valid = 0;
        mode = 0;
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] data, input int lat, input bit stall);
        int w, n0;
        rd_lat = lat;
        mem_data = data;
        ack_q.push_back(5);
        rd_q.push_back(addr[9:0]);
        split_q.push_back(lat);
        for (int i = 7; i >= 0; i--) bit_q.push_back(data[i]);
        mode = 0;
        send_bits(addr, 16, w);
        check("read accept latency", w, 1);
        master_valid = 0;
        n0 = rd_bits;
        for (int t = 0; t < 100 && rd_bits < n0 + 8; t++) begin
            step();
            master_ready = stall ? ~master_ready : 1'b1;
        end
        check("read bits received", rd_bits - n0, 8);
        master_ready = 1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        int  w;
        bit  bad;
        #2 rstn = 0;
        #10 check("reset outputs", {ack, slave_ready, slave_valid, split, rd_bus, s_wr_en, s_rd_en, s_addr, s_wr_data}, 0);
        @(posedge clk);
        #3 rstn = 1;
        step();
        do_write(16'h0455, 8'hA5);
        step();
        do_read(16'h0412, 8'h3C, 3, 0);
        do_read(16'h0412, 8'h3C, 1, 1);
        // select mismatch: hold master_valid in IGNORE, then drop it
        mode = 1;
        send_bits(16'h0002, 6, w);
        check("mismatch accept latency", w, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ignore holds slave_ready low", slave_ready, 0);
            step();
        end
        master_valid = 0;
        step();
        do_write(16'h0455, 8'h5A);
        step();
        // abort after 8 address bits
        ack_q.push_back(5);
        mode = 1;
        send_bits(16'h0004, 8, w);
        master_valid = 0;
        step();
        do_write(16'h0401, 8'h7E);
        step();
        // reset while waiting for read data
        rd_lat = 6;
        mem_data = 8'hC3;
        ack_q.push_back(5);
        rd_q.push_back(10'h012);
        mode = 0;
        send_bits(16'h0412, 16, w);
        master_valid = 0;
        step();
        @(posedge clk);
        #3 check("split before reset", split, 1);
        check("s_addr before reset", s_addr, 10'h012);
        rstn = 0;
        #1 check("async reset outputs", {ack, slave_ready, slave_valid, split, rd_bus, s_wr_en, s_rd_en, s_addr, s_wr_data}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rstn = 1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (slave_ready | slave_valid | split | ack | s_rd_en | s_wr_en) bad = 1;
        end
        check("idle after reset with stale s_rd_valid", bad, 0);
        step();
        do_write(16'h07FF, 8'h3C);
        step();
        step();
        check("write queue drained", wr_q.size(), 0);
        check("read queue drained", rd_q.size(), 0);
        check("ack queue drained", ack_q.size(), 0);
        check("bit queue drained", bit_q.size(), 0);
        check("split queue drained", split_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Responder end of the serial system bus. It pairs with the bus-side initiator port.
- Deserialises the 16-bit address (MSB first) and the write data from the initiator.
- Decodes the 6-bit device select and drives ack.
- Performs a single access on a local memory interface, and serialises read data back to the initiator.
- Sits between the bus interconnect and one slave memory/peripheral.

Parameters:
- DEV_ID, 6'b000001, device select; compared against address bits [15:10].
- SPLIT_EN, 1, when 1, split is asserted while a read waits for memory data.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- mode  input  1  transfer direction from initiator; 1 = write, 0 = read
- wr_bus  input  1  serial address/write-data bit from initiator, MSB first
- rd_bus  output  1  serial read-data bit to initiator, MSB first
- ack  output  1  device-select acknowledge
- master_valid  input  1  initiator has a valid address/write bit on wr_bus
- slave_ready  output  1  this port accepts a bit on wr_bus
- master_ready  input  1  initiator accepts a bit on rd_bus
- slave_valid  output  1  this port presents a valid bit on rd_bus
- split  output  1  read data pending; bus may be released
- s_addr  output  10  local address (address bits [9:0])
- s_wr_data  output  8  write data to memory
- s_wr_en  output  1  one-cycle memory write strobe
- s_rd_en  output  1  one-cycle memory read strobe
- s_rd_data  input  8  read data from memory
- s_rd_valid  input  1  s_rd_data valid; any latency ≥1 cycle after s_rd_en

Behaviour:
- Reset (async, rstn low):
  - State goes to IDLE; all shift registers and counters clear.
  - All outputs are 0, including s_addr and s_wr_data.
  - Reset mid-transfer aborts with no memory strobe.
- Handshake:
  - A bit on wr_bus transfers at a posedge where master_valid & slave_ready.
  - A bit on rd_bus transfers at a posedge where slave_valid & master_ready.
  - Bits are held until transferred.
- slave_ready is 1 only in ADDR_SEL, ADDR_LO and WDATA.
- slave_valid is 1 only in RDATA. rd_bus = rd_sr[7].
- split = SPLIT_EN & (state == RD_WAIT).
- ack is combinational. It is 1 only in ADDR_SEL with bit_cnt == 5, master_valid = 1, and {sel_sr[4:0], wr_bus} == DEV_ID. This is the cycle of the 6th address-bit transfer.
- State transitions:
  - IDLE: on master_valid, latch mode into t_mode, clear bit_cnt, go to ADDR_SEL. This adds one cycle of latency before slave_ready is asserted.
  - ADDR_SEL: shift wr_bus into sel_sr on each transfer. On the 6th transfer (bit_cnt == 5), go to ADDR_LO if the select matches; otherwise go to IGNORE. Clear bit_cnt on exit.
  - ADDR_LO: shift 10 bits into s_addr. After the 10th bit, go to WDATA if t_mode = 1; otherwise go to RD_WAIT.
  - RD_WAIT is entered with s_rd_en pulsed in the first cycle.
  - WDATA: shift 8 bits into wdata_sr. After the 8th bit, go to WRITE.
  - WRITE: one cycle. s_wr_en = 1, s_wr_data = wdata_sr, s_addr stable. Then go to IDLE.
  - RD_WAIT: hold until s_rd_valid. On s_rd_valid, capture s_rd_data into rd_sr and go to RDATA. s_rd_valid in the same cycle as s_rd_en is ignored.
  - RDATA: shift rd_sr left on each transfer. After the 8th transfer, go to IDLE.
  - IGNORE: wait for master_valid = 0, then go to IDLE. No strobes are issued in this state.
- Abort: master_valid = 0 while in ADDR_SEL, ADDR_LO or WDATA (initiator timeout or drop) returns to IDLE next cycle, with no memory strobe.
- Counters and outputs:
  - bit_cnt is 4 bits and wraps only via explicit clear at each phase exit.
  - s_addr holds its last value after the transaction.
  - s_wr_en and s_rd_en are each exactly one cycle per transaction.
- Back-to-back: a new master_valid is accepted in the first IDLE cycle after completion.

Test Plan:
- Write, addr 0x0455, data 0xA5, no stalls:
  - ack = 1 for exactly one cycle, on the 6th bit.
  - s_wr_en is a single pulse with s_addr = 0x055 and s_wr_data = 0xA5.
  - Port is in IDLE the cycle after the strobe.
- Read, addr 0x0412, s_rd_valid 3 cycles after s_rd_en, s_rd_data = 0x3C:
  - s_rd_en is a single pulse with s_addr = 0x012.
  - split = 1 for the 3 wait cycles.
  - rd_bus sequence is 0,0,1,1,1,1,0,0.
  - Then IDLE.
- Read with master_ready low on alternate cycles: every bit is held until its transfer; 0x3C is received intact.
- Select mismatch, addr 0x0855:
  - ack stays 0; port enters IGNORE.
  - s_wr_en and s_rd_en stay 0.
  - Port returns to IDLE one cycle after master_valid falls.
- Abort: master_valid drops after 8 address bits → IDLE next cycle; no strobe. A following write to 0x0401 with 0x7E completes correctly.
- Reset mid-RD_WAIT:
  - All outputs go to 0 immediately (asynchronously).
  - Port stays idle after reset release until master_valid.
  - A stale s_rd_valid after reset produces no output.
